// File: rtl/def_cpu.sv
// Shared types for the memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester owns the current downstream transaction
//   mem_req_t   : registered downstream request (write enable, address, data, strobes)
// The struct is sized by the package widths; the arbiter's width parameters default to them.
package def_cpu;

  localparam int unsigned ArbAddrW = 64;
  localparam int unsigned ArbDataW = 64;
  localparam int unsigned ArbStrbW = ArbDataW / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  typedef struct packed {
    logic                we;
    logic [ArbAddrW-1:0] addr;
    logic [ArbDataW-1:0] wdata;
    logic [ArbStrbW-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/arb_streak_cnt.sv
// Saturating counter of consecutive load/store grants made while a fetch is waiting.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : count one more D grant (saturates at MAX)
//   clr_i    : clear the count; wins over inc_i
//   sat_o    : count has reached MAX, so the waiting fetch must win next
module arb_streak_cnt #(
  parameter int unsigned MAX  = 4,
  parameter int unsigned CntW = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CntW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-outstanding memory port between the fetch (I) and load/store (D) requesters.
// D has priority; after MAX_D_STREAK consecutive D grants with a fetch waiting, the fetch wins.
// A fetch can be aborted while in flight: the downstream transaction completes, i_ready is dropped.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   i_req/i_addr/i_abort          : fetch request, address, front-end flush
//   i_ready_o/i_rdata_o           : 1-cycle fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata/d_wstrb : load/store request
//   d_ready_o/d_rdata_o           : 1-cycle load data / store ack pulse and data
//   mem_req/we/addr/wdata/wstrb_o : downstream request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : downstream accept and response
module mem_bus_arbiter
  import def_cpu::*;
#(
  parameter int unsigned ADDR_W       = ArbAddrW,
  parameter int unsigned DATA_W       = ArbDataW,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic                i_abort_i,
  output logic                i_ready_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_ready_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  mem_req_t    req_q, req_d;
  logic        abort_pend_q, abort_pend_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic streak_sat;
  logic streak_inc;
  logic streak_clr;
  logic grant_i;

  arb_streak_cnt #(
    .MAX (MAX_D_STREAK)
  ) u_streak (
    .clk   (clk),
    .rst   (rst),
    .inc_i (streak_inc),
    .clr_i (streak_clr),
    .sat_o (streak_sat)
  );

  // Fetch wins only when alone, or when D has used up its streak allowance.
  assign grant_i = i_req_i && (!d_req_i || streak_sat);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    abort_pend_d = abort_pend_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    streak_inc   = 1'b0;
    streak_clr   = !i_req_i;

    unique case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          state_d      = REQ;
          abort_pend_d = 1'b0;
          if (grant_i) begin
            owner_d     = OWN_I;
            req_d.we    = 1'b0;
            req_d.addr  = i_addr_i;
            req_d.wdata = '0;
            req_d.wstrb = '0;
            streak_clr  = 1'b1;
          end else begin
            owner_d     = OWN_D;
            req_d.we    = d_we_i;
            req_d.addr  = d_addr_i;
            req_d.wdata = d_wdata_i;
            req_d.wstrb = d_we_i ? d_wstrb_i : '0;
            streak_inc  = i_req_i;
          end
        end
      end
      REQ: begin
        if (i_abort_i && (owner_q == OWN_I)) begin
          abort_pend_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d      = IDLE;
          abort_pend_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_rdata_i;
          end else if (!(abort_pend_q || i_abort_i)) begin
            // An abort arriving with the response still drops it.
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata_i;
          end
        end else if (i_abort_i && (owner_q == OWN_I)) begin
          abort_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      req_q        <= '0;
      abort_pend_q <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      req_q        <= req_d;
      abort_pend_q <= abort_pend_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wstrb_o = req_q.wstrb;
  assign i_ready_o   = i_ready_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned MaxStreak = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_abort = 1'b0;
  logic [63:0] i_addr = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic [7:0]  d_wstrb = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        i_ready_o, d_ready_o, mem_req_o, mem_we_o;
  logic [63:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wstrb_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W       (64),
    .DATA_W       (64),
    .MAX_D_STREAK (MaxStreak)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_i      (i_req),
    .i_addr_i     (i_addr),
    .i_abort_i    (i_abort),
    .i_ready_o    (i_ready_o),
    .i_rdata_o    (i_rdata_o),
    .d_req_i      (d_req),
    .d_we_i       (d_we),
    .d_addr_i     (d_addr),
    .d_wdata_i    (d_wdata),
    .d_wstrb_i    (d_wstrb),
    .d_ready_o    (d_ready_o),
    .d_rdata_o    (d_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  // A fetch may only be withdrawn by completion or by a flush.
  a_i_hold: assert property (@(posedge clk) disable iff (rst)
    $fell(i_req) |-> (i_abort || i_ready_o));

  int unsigned n_vec = 0, n_err = 0;
  int          cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Requester agents
  bit i_pend = 0, d_pend = 0;

  // Memory slave model
  int          gnt_dly = 0, rv_wait = 0;
  bit          rand_dly = 0, rand_data = 0, stray_en = 0;
  int          s_cnt = -1, s_rv = 0;
  bit          s_outst = 0, resp_now = 0;
  logic [63:0] s_data = '0, next_rdata = '0;

  // Reference model: one transaction outstanding, owner chosen by the priority/starvation rule
  bit          t_valid = 0, t_owner_d = 0, t_abort = 0;
  logic        t_we;
  logic [63:0] t_addr, t_wdata;
  logic [7:0]  t_wstrb;
  int          streak_m = 0;
  bit          prev_mem_req = 0;
  bit          order_q[$];
  int          grant_cyc_q[$];
  int          req_hi_cnt = 0;
  int          i_ready_cnt = 0, d_ready_cnt = 0, last_d_ready_cyc = 0;
  logic [63:0] last_i_rdata = '0, last_d_rdata = '0;

  task automatic monitor();
    bit rose, exp_rise, exp_i, exp_d, d_win;
    rose = mem_req_o && !prev_mem_req;
    if (i_abort && t_valid && !t_owner_d) t_abort = 1;
    exp_i = resp_now && t_valid && !t_owner_d && !t_abort;
    exp_d = resp_now && t_valid && t_owner_d;
    check_eq("i_ready", i_ready_o, exp_i);
    check_eq("d_ready", d_ready_o, exp_d);
    if (exp_i) check_eq("i_rdata", i_rdata_o, mem_rdata);
    if (exp_d) check_eq("d_rdata", d_rdata_o, mem_rdata);
    if (i_ready_o) begin i_ready_cnt++; last_i_rdata = i_rdata_o; end
    if (d_ready_o) begin d_ready_cnt++; last_d_rdata = d_rdata_o; last_d_ready_cyc = cyc; end
    exp_rise = !t_valid && (i_req || d_req);
    if (resp_now) t_valid = 0;
    check_eq("mem_req_rise", rose, exp_rise);
    if (rose) begin
      d_win = d_req && !(i_req && streak_m == MaxStreak);
      if (d_win) begin
        t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_wstrb = d_we ? d_wstrb : 8'h00;
        streak_m = i_req ? ((streak_m < MaxStreak) ? streak_m + 1 : MaxStreak) : 0;
      end else begin
        t_we = 1'b0; t_addr = i_addr; t_wdata = '0; t_wstrb = 8'h00;
        streak_m = 0;
      end
      t_valid = 1; t_abort = 0; t_owner_d = d_win;
      order_q.push_back(d_req && mem_we_o == d_we && mem_addr_o == d_addr);
      grant_cyc_q.push_back(cyc);
      req_hi_cnt = 0;
    end else if (!i_req) begin
      streak_m = 0;
    end
    if (mem_req_o) begin
      req_hi_cnt++;
      check_eq("mem_we", mem_we_o, t_we);
      check_eq("mem_addr", mem_addr_o, t_addr);
      check_eq("mem_wdata", mem_wdata_o, t_wdata);
      check_eq("mem_wstrb", mem_wstrb_o, t_wstrb);
    end
    prev_mem_req = mem_req_o;
  endtask

  task automatic drive_slave();
    mem_gnt = 0; mem_rvalid = 0; resp_now = 0;
    if (s_outst) begin
      if (s_rv == 0) begin
        mem_rvalid = 1; mem_rdata = s_data; resp_now = 1; s_outst = 0;
      end else s_rv--;
    end else if (mem_req_o) begin
      if (s_cnt < 0) s_cnt = rand_dly ? int'($urandom_range(3, 0)) : gnt_dly;
      if (s_cnt == 0) begin
        mem_gnt = 1; s_outst = 1; s_cnt = -1;
        s_rv   = rand_dly ? int'($urandom_range(3, 0)) : rv_wait;
        s_data = rand_data ? {$urandom, $urandom} : next_rdata;
      end else s_cnt--;
    end
    if (stray_en && !s_outst && !mem_gnt && !mem_rvalid) begin
      if ($urandom_range(7, 0) == 0) begin
        mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
      end else if (!mem_req_o && $urandom_range(7, 0) == 0) begin
        mem_gnt = 1;
      end
    end
  endtask

  task automatic drive_agents();
    i_abort = 0;
    if (i_pend && i_ready_o) begin i_pend = 0; i_req = 0; end
    if (d_pend && d_ready_o) begin d_pend = 0; d_req = 0; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    drive_slave();
    drive_agents();
  endtask

  task automatic issue_i(input logic [63:0] a);
    i_req = 1; i_addr = a; i_pend = 1;
  endtask

  task automatic issue_d(input logic we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] ws);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws; d_pend = 1;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while ((i_pend || d_pend || t_valid) && n < bound) begin step(); n++; end
    check_eq(tag, (n < bound), 1'b1);
    step(); step();
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    do begin step(); n++; end while (!mem_gnt && n < 20);
    check_eq(tag, mem_gnt, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, mem_req_o, 0);
    check_eq({tag, "_mem_we"}, mem_we_o, 0);
    check_eq({tag, "_mem_addr"}, mem_addr_o, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check_eq({tag, "_mem_wstrb"}, mem_wstrb_o, 0);
    check_eq({tag, "_i_ready"}, i_ready_o, 0);
    check_eq({tag, "_d_ready"}, d_ready_o, 0);
    check_eq({tag, "_i_rdata"}, i_rdata_o, 0);
    check_eq({tag, "_d_rdata"}, d_rdata_o, 0);
  endtask

  bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int t0, n, cnt_before;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // Single load: fields registered, ready 3 cycles after request
    next_rdata = 64'h1122_3344_5566_7788;
    issue_d(1'b0, 64'h8000_0010, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    t0 = cyc;
    cnt_before = d_ready_cnt;
    drain("load_done", 20);
    check_eq("load_latency", last_d_ready_cyc - t0, 3);
    check_eq("load_data", last_d_rdata, 64'h1122_3344_5566_7788);
    check_eq("load_ready_cnt", d_ready_cnt - cnt_before, 1);
    check_eq("load_wstrb", t_wstrb, 8'h00);

    // Simultaneous requests: D first, I in the IDLE right after d_ready
    order_q.delete(); grant_cyc_q.delete();
    next_rdata = 64'hA5A5_0000_1111_2222;
    issue_i(64'h4000);
    issue_d(1'b0, 64'h5000, '0, 8'h00);
    drain("simul_done", 40);
    check_eq("simul_cnt", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check_eq("simul_first_d", order_q[0], 1'b1);
      check_eq("simul_second_i", order_q[1], 1'b0);
      check_eq("simul_i_grant_cyc", grant_cyc_q[1], last_d_ready_cyc + 1);
    end

    // Starvation: D and I both held continuously
    order_q.delete(); grant_cyc_q.delete();
    issue_i(64'h1_0000);
    issue_d(1'b0, 64'h2_0000, '0, 8'h00);
    n = 0;
    while (order_q.size() < 10 && n < 200) begin
      step(); n++;
      if (order_q.size() < 10) begin
        if (!i_pend) issue_i(64'h1_0000 + 64'(n * 8));
        if (!d_pend) issue_d(1'b0, 64'h2_0000 + 64'(n * 8), '0, 8'h00);
      end
    end
    check_eq("starve_grants", (order_q.size() >= 10), 1'b1);
    for (int k = 0; k < 10 && k < order_q.size(); k++)
      check_eq($sformatf("starve_order%0d", k), order_q[k], exp_order[k]);
    drain("starve_done", 60);

    // Abort an in-flight fetch; the next fetch returns its own data
    rv_wait = 2;
    next_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    cnt_before = i_ready_cnt;
    issue_i(64'h1000);
    wait_gnt("abort_gnt");
    step();
    i_abort = 1; i_req = 0; i_pend = 0;
    step();
    next_rdata = 64'h2222_3333_4444_5555;
    rv_wait = 0;
    issue_i(64'h2000);
    drain("abort_done", 40);
    check_eq("abort_ready_cnt", i_ready_cnt - cnt_before, 1);
    check_eq("abort_next_data", last_i_rdata, 64'h2222_3333_4444_5555);

    // Store with grant stalled 5 cycles
    gnt_dly = 5;
    cnt_before = d_ready_cnt;
    issue_d(1'b1, 64'h9000, 64'h0123_4567_89AB_CDEF, 8'h0F);
    wait_gnt("store_gnt");
    check_eq("store_req_cycles", req_hi_cnt, 6);
    drain("store_done", 20);
    check_eq("store_ready_cnt", d_ready_cnt - cnt_before, 1);
    gnt_dly = 0;

    // Reset in the middle of a load in WAIT
    rv_wait = 3;
    next_rdata = 64'h5555_6666_7777_8888;
    issue_d(1'b0, 64'h7000, '0, 8'h00);
    wait_gnt("rst_gnt");
    step();
    rst = 1;
    #1;
    check_all_zero("midrst");
    d_req = 0; d_pend = 0; i_req = 0; i_pend = 0;
    t_valid = 0; s_outst = 0; s_cnt = -1; streak_m = 0; prev_mem_req = 0;
    mem_gnt = 0; mem_rvalid = 0; resp_now = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    cnt_before = d_ready_cnt;
    mem_rvalid = 1; mem_rdata = 64'hDEAD;
    step();
    step();
    step();
    check_eq("rst_no_ready", d_ready_cnt - cnt_before, 0);
    rv_wait = 0;

    // Randomized traffic with stray handshakes and random aborts
    rand_dly = 1; rand_data = 1; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (i_pend && t_valid && !t_owner_d && !mem_rvalid && $urandom_range(15, 0) == 0) begin
        i_abort = 1; i_req = 0; i_pend = 0;
      end else if (!i_pend && $urandom_range(3, 0) == 0) begin
        issue_i({$urandom, $urandom});
      end
      if (!d_pend && $urandom_range(2, 0) == 0)
        issue_d(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
    end
    stray_en = 0;
    drain("random_done", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
